crossbar_nxn_stream: RTL and testbench



---
 rtl/crossbar_nxn_stream.sv | 103 ++++++++++
 tb/tb_crossbar_nxn_stream.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/crossbar_nxn_stream.sv
// Registered PORTS x PORTS stream crossbar: one round-robin arbiter and one
// output register per destination, valid/ready on every port.
module crossbar_nxn_stream #(
    parameter int PORTS = 4,
    parameter int WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORTS*WIDTH-1:0]           in_data,
    input  logic [PORTS*$clog2(PORTS)-1:0]   in_dest,
    input  logic [PORTS-1:0]                 in_valid,
    output logic [PORTS-1:0]                 in_ready,
    output logic [PORTS*WIDTH-1:0]           out_data,
    output logic [PORTS*$clog2(PORTS)-1:0]   out_src,
    output logic [PORTS-1:0]                 out_valid,
    input  logic [PORTS-1:0]                 out_ready
);
    localparam int DW = $clog2(PORTS);

    // Handshake: a word moves on any port when valid & ready are both high at
    // a rising edge; sources hold valid/data/dest stable until that happens.

    logic [WIDTH-1:0] r_out_data  [PORTS];
    logic [DW-1:0]    r_out_src   [PORTS];
    logic [PORTS-1:0] r_out_valid;
    logic [DW-1:0]    r_ptr       [PORTS];

    logic [PORTS-1:0] w_can_accept;
    logic [PORTS-1:0] w_req       [PORTS];
    logic [PORTS-1:0] w_gnt       [PORTS];
    logic [PORTS-1:0] w_gnt_any;
    logic [DW-1:0]    w_gnt_idx   [PORTS];
    logic [WIDTH-1:0] w_gnt_data  [PORTS];

    // Reset also blocks acceptance so in_ready reads 0 while rst is high.
    always_comb begin
        for (int j = 0; j < PORTS; j++) begin
            w_can_accept[j] = !rst && (!r_out_valid[j] || out_ready[j]);
            for (int i = 0; i < PORTS; i++) begin
                w_req[j][i] = in_valid[i] && (in_dest[i*DW +: DW] == DW'(j));
            end
        end
    end

    always_comb begin
        logic [DW-1:0] w_idx;
        w_idx = '0;
        for (int j = 0; j < PORTS; j++) begin
            w_gnt[j]      = '0;
            w_gnt_any[j]  = 1'b0;
            w_gnt_idx[j]  = '0;
            w_gnt_data[j] = '0;
            // Scan from the pointer upward; DW-bit addition wraps modulo PORTS.
            for (int k = 0; k < PORTS; k++) begin
                w_idx = r_ptr[j] + DW'(k);
                if (!w_gnt_any[j] && w_req[j][w_idx] && w_can_accept[j]) begin
                    w_gnt_any[j]    = 1'b1;
                    w_gnt_idx[j]    = w_idx;
                    w_gnt[j][w_idx] = 1'b1;
                    w_gnt_data[j]   = in_data[int'(w_idx)*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int j = 0; j < PORTS; j++) begin
            in_ready = in_ready | w_gnt[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= '0;
            for (int j = 0; j < PORTS; j++) begin
                r_out_data[j] <= '0;
                r_out_src[j]  <= '0;
                r_ptr[j]      <= '0;
            end
        end else begin
            for (int j = 0; j < PORTS; j++) begin
                if (w_gnt_any[j]) begin
                    r_out_data[j]  <= w_gnt_data[j];
                    r_out_src[j]   <= w_gnt_idx[j];
                    r_out_valid[j] <= 1'b1;
                    r_ptr[j]       <= w_gnt_idx[j] + 1'b1;
                end else if (out_ready[j]) begin
                    r_out_valid[j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < PORTS; j++) begin
            out_data[j*WIDTH +: WIDTH] = r_out_data[j];
            out_src[j*DW +: DW]        = r_out_src[j];
        end
        out_valid = r_out_valid;
    end

endmodule

// File: tb/tb_crossbar_nxn_stream.sv
// Directed bench for crossbar_nxn_stream (4 ports, 4-bit words).
module tb_crossbar_nxn_stream;
    localparam int PORTS = 4;
    localparam int WIDTH = 4;
    localparam int DW    = 2;

    logic                   clk;
    logic                   rst;
    logic [PORTS*WIDTH-1:0] in_data;
    logic [PORTS*DW-1:0]    in_dest;
    logic [PORTS-1:0]       in_valid;
    logic [PORTS-1:0]       in_ready;
    logic [PORTS*WIDTH-1:0] out_data;
    logic [PORTS*DW-1:0]    out_src;
    logic [PORTS-1:0]       out_valid;
    logic [PORTS-1:0]       out_ready;

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [DW-1:0]    src_q[$];

    crossbar_nxn_stream #(.PORTS(PORTS), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_dest  (in_dest),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_src  (out_src),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic set_in(input logic [PORTS-1:0] vld, input logic [PORTS*WIDTH-1:0] d,
                          input logic [PORTS*DW-1:0] dst);
        in_valid = vld;
        in_data  = d;
        in_dest  = dst;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] held_d;
    logic [DW-1:0]    held_s;

    initial begin
        rst       = 1'b0;
        out_ready = '0;
        set_in(4'b0000, '0, '0);
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data",  32'(out_data),  32'h0);
        check("rst_out_src",   32'(out_src),   32'h0);
        tick();
        tick();
        #1 rst = 1'b0;
        tick();

        // full permutation: dest 3,2,1,0 for inputs 0..3
        out_ready = 4'b1111;
        set_in(4'b1111, 16'h4321, 8'h1B);
        #1;
        check("perm_in_ready", 32'(in_ready), 32'hF);
        tick();
        set_in(4'b0000, 16'h4321, 8'h1B);
        out_ready = 4'b0000;
        check("perm_out_data",  32'(out_data),  32'h1234);
        check("perm_out_src",   32'(out_src),   32'h1B);
        check("perm_out_valid", 32'(out_valid), 32'hF);

        // async reset while every output is full
        set_in(4'b1111, 16'h4321, 8'hFF);
        #1 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'h0);
        check("async_rst_out_data",  32'(out_data),  32'h0);
        check("async_rst_out_src",   32'(out_src),   32'h0);
        check("async_rst_in_ready",  32'(in_ready),  32'h0);
        #1 rst = 1'b0;
        out_ready = 4'b1111;
        #1;
        // p_3 was 1 before reset; input 0 must win again
        check("post_rst_in_ready", 32'(in_ready), 32'h1);
        tick();
        set_in(4'b0000, 16'h4321, 8'hFF);
        check("post_rst_out3_data", 32'(out_data[3*WIDTH +: WIDTH]), 32'h1);
        check("post_rst_out3_src",  32'(out_src[3*DW +: DW]),        32'h0);

        // contention at output 0, requests held for five grants
        for (int c = 0; c < 5; c++) begin
            exp_q.push_back(WIDTH'(8 + (c % 4)));
            src_q.push_back(DW'(c % 4));
        end
        set_in(4'b1111, 16'hBA98, 8'h00);
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("cont_in_ready_%0d", c), 32'(in_ready), 32'(1 << (c % 4)));
            tick();
            check($sformatf("cont_data_%0d", c), 32'(out_data[0 +: WIDTH]), 32'(exp_q.pop_front()));
            check($sformatf("cont_src_%0d", c),  32'(out_src[0 +: DW]),      32'(src_q.pop_front()));
            check($sformatf("cont_valid_%0d", c), 32'(out_valid[0]), 32'h1);
        end

        // drain-only at output 0
        set_in(4'b0000, 16'hBA98, 8'h00);
        held_d = out_data[0 +: WIDTH];
        held_s = out_src[0 +: DW];
        tick();
        check("drain_valid", 32'(out_valid[0]),          32'h0);
        check("drain_data",  32'(out_data[0 +: WIDTH]),  32'(held_d));
        check("drain_src",   32'(out_src[0 +: DW]),      32'(held_s));
        check("drain_data_val", 32'(out_data[0 +: WIDTH]), 32'h8);

        // backpressure at output 1 from input 2
        out_ready = 4'b1101;
        set_in(4'b0100, 16'h0500, 8'h10);
        #1;
        check("bp_first_ready", 32'(in_ready), 32'h4);
        tick();
        set_in(4'b0100, 16'h0600, 8'h10);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp_stall_ready_%0d", c), 32'(in_ready[2]), 32'h0);
            check($sformatf("bp_hold_data_%0d", c), 32'(out_data[1*WIDTH +: WIDTH]), 32'h5);
            check($sformatf("bp_hold_valid_%0d", c), 32'(out_valid[1]), 32'h1);
            tick();
        end
        out_ready = 4'b1111;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'h4);
        tick();
        set_in(4'b0000, 16'h0600, 8'h10);
        check("bp_new_data",  32'(out_data[1*WIDTH +: WIDTH]), 32'h6);
        check("bp_new_src",   32'(out_src[1*DW +: DW]),        32'h2);
        check("bp_new_valid", 32'(out_valid[1]),               32'h1);
        tick();
        check("bp_no_dup", 32'(out_valid[1]), 32'h0);

        // pointer wrap at output 2: grant input 3, then 0 and 3 compete
        set_in(4'b1000, 16'hC000, 8'h80);
        #1;
        check("wrap_first_ready", 32'(in_ready), 32'h8);
        tick();
        check("wrap_first_data", 32'(out_data[2*WIDTH +: WIDTH]), 32'hC);
        set_in(4'b1001, 16'hC00D, 8'h82);
        #1;
        check("wrap_second_ready", 32'(in_ready), 32'h1);
        tick();
        set_in(4'b0000, 16'h0000, 8'h00);
        check("wrap_second_data", 32'(out_data[2*WIDTH +: WIDTH]), 32'hD);
        check("wrap_second_src",  32'(out_src[2*DW +: DW]),        32'h0);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
